icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: INDEX_BITS, 4, log2 of line count; 2^INDEX_BITS direct-mapped lines, one 32-bit word each.
REQ-002 Port: clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_in  input  1  reset, asynchronous, active-low.
REQ-004 Port: rdy_in  input  1  global ready; low = hold all state and outputs.
REQ-005 Port: clear_in  input  1  pipeline flush (branch mispredict); drops the pending fetch.
REQ-006 Port: fetch_valid  input  1  fetch stage presents a PC.
REQ-007 Port: fetch_pc  input  32  instruction address; bits [1:0] ignored.
REQ-008 Port: fetch_ready  output  1  icache can accept a fetch this cycle.
REQ-009 Port: inst_valid  output  1  one-cycle pulse: inst holds the word for the last accepted PC.
REQ-010 Port: inst  output  32  instruction word.
REQ-011 Port: icache_in  output  1  miss request to memory controller; held until acknowledged.
REQ-012 Port: icache_address_in  output  32  word-aligned miss address.
REQ-013 Port: icache_received  input  1  controller accepted request (one-cycle pulse).
REQ-014 Port: icache_task_out  input  1  controller returns data (one-cycle pulse).
REQ-015 Port: value_load  input  32  returned word; valid only while icache_task_out=1.

Function
REQ-016 Address split: index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2]; storage per line = valid bit, tag, data.
REQ-017 States: IDLE, REQ, WAIT; fetch_ready = 1 only in IDLE and clear_in=0.
REQ-018 IDLE, fetch_valid=1, clear_in=0: latch PC; hit (valid and tag match) -> inst_valid=1 with line data next cycle, stay IDLE (1-cycle hit latency, back-to-back hits each cycle).
REQ-019 IDLE miss: go REQ; drive icache_in=1, icache_address_in={pc[31:2],2'b00} from next cycle.
REQ-020 REQ: hold icache_in and address stable until icache_received=1; then deassert icache_in next cycle and go WAIT.
REQ-021 WAIT: on icache_task_out=1 write value_load into indexed line, set valid, store tag; return IDLE; if not flushed assert inst_valid=1, inst=value_load next cycle.
REQ-022 icache_task_out ignored outside WAIT; icache_received ignored outside REQ.
REQ-023 clear_in in IDLE: no fetch accepted, any inst_valid for that cycle suppressed (inst_valid=0 next cycle).
REQ-024 clear_in in REQ or WAIT: set internal drop flag; transaction continues to completion (controller cannot abort); line still filled; inst_valid stays 0; drop flag clears on return to IDLE.
REQ-025 clear_in and icache_task_out same cycle: fill line, suppress inst_valid.
REQ-026 rdy_in=0: no state, storage or output change; pulses are not lost, they resume when rdy_in returns.
REQ-027 At most one outstanding miss; no prefetch; cache never written other than by fills.
REQ-028 inst_valid is a single-cycle pulse; inst holds last value when inst_valid=0.

Reset
REQ-029 rst_in=0 immediately (no clock): state IDLE, all valid bits 0, drop flag 0.
REQ-030 Reset outputs: fetch_ready=1 after release, inst_valid=0, inst=0, icache_in=0, icache_address_in=0.
REQ-031 Reset mid-miss abandons transaction; first cycle after release, a late icache_task_out is ignored.

Verification
REQ-032 Cold miss: fetch 0x0000_1004 -> icache_in=1 addr 0x0000_1004; received pulse, then task_out with 0x00A0_0093 -> inst_valid=1, inst=0x00A0_0093; refetch 0x1004 -> hit, inst_valid next cycle, no icache_in.
REQ-033 Conflict: fill 0x0000_0008 then 0x0000_0048 (same index, INDEX_BITS=4) -> second misses and replaces; refetch 0x08 misses again.
REQ-034 Flush in WAIT: miss on 0x200, clear_in during WAIT -> data arrives, inst_valid stays 0; refetch 0x200 hits.
REQ-035 Stall: rdy_in=0 for 5 cycles during REQ -> icache_in and address unchanged, no state change; completes normally after.
REQ-036 Async reset with valid lines and pending miss -> all outputs reset without clock edge; subsequent fetch of previously cached PC misses.
REQ-037 Back-to-back hits on 4 cached PCs -> 4 consecutive inst_valid pulses, correct words in order.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Hits answer one cycle after the fetch; a miss holds a single request to the memory controller until its word returns.
module icache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        fetch_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic        icache_in,
    output logic [31:0] icache_address_in,
    input  logic        icache_received,
    input  logic        icache_task_out,
    input  logic [31:0] value_load
);
    // state | meaning
    // IDLE  | accepting fetches; a hit is answered on the next cycle
    // REQ   | miss request held on icache_in until the controller accepts it
    // WAIT  | request accepted; waiting for the returned word

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [TAG_BITS-1:0]   tag_d  [LINES];
    logic [31:0]           data_q [LINES];
    logic [31:0]           data_d [LINES];
    logic [31:2]           pc_q, pc_d;
    logic                  drop_q, drop_d;
    logic                  inst_valid_q, inst_valid_d;
    logic [31:0]           inst_q, inst_d;
    logic                  req_q, req_d;
    logic [31:0]           addr_q, addr_d;

    logic [INDEX_BITS-1:0] fetch_idx;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  lookup_hit;
    logic [1:0]            unused_pc_bits;

    assign fetch_idx      = fetch_pc[INDEX_BITS+1:2];
    assign fetch_tag      = fetch_pc[31:INDEX_BITS+2];
    assign fill_idx       = pc_q[INDEX_BITS+1:2];
    assign fill_tag       = pc_q[31:INDEX_BITS+2];
    assign lookup_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign unused_pc_bits = fetch_pc[1:0];

    assign fetch_ready       = (state_q == IDLE) && !clear_in;
    assign inst_valid        = inst_valid_q;
    assign inst              = inst_q;
    assign icache_in         = req_q;
    assign icache_address_in = addr_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        req_d        = req_q;
        addr_d       = addr_q;

        // With rdy_in low everything, including a pending inst_valid pulse, is frozen.
        if (rdy_in) begin
            inst_valid_d = 1'b0;
            case (state_q)
                IDLE: begin
                    drop_d = 1'b0;
                    if (fetch_valid && !clear_in) begin
                        pc_d = fetch_pc[31:2];
                        if (lookup_hit) begin
                            inst_valid_d = 1'b1;
                            inst_d       = data_q[fetch_idx];
                        end else begin
                            state_d = REQ;
                            req_d   = 1'b1;
                            addr_d  = {fetch_pc[31:2], 2'b00};
                        end
                    end
                end
                REQ: begin
                    drop_d = drop_q | clear_in;
                    if (icache_received) begin
                        req_d   = 1'b0;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    drop_d = drop_q | clear_in;
                    if (icache_task_out) begin
                        // The line is filled even when the fetch was flushed.
                        valid_d[fill_idx] = 1'b1;
                        tag_d[fill_idx]   = fill_tag;
                        data_d[fill_idx]  = value_load;
                        state_d           = IDLE;
                        drop_d            = 1'b0;
                        if (!drop_q && !clear_in) begin
                            inst_valid_d = 1'b1;
                            inst_d       = value_load;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
            pc_q         <= '0;
            drop_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            req_q        <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: a transaction-level cache/memory model predicts hits, miss addresses and returned words;
// one negedge monitor compares the DUT outputs against it every cycle.
module tb_icache;
    localparam int INDEX_BITS = 4;
    localparam int LINES      = 1 << INDEX_BITS;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic        icache_in;
    logic [31:0] icache_address_in;
    logic        icache_received;
    logic        icache_task_out;
    logic [31:0] value_load;

    icache #(.INDEX_BITS(INDEX_BITS)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .clear_in          (clear_in),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_ready       (fetch_ready),
        .inst_valid        (inst_valid),
        .inst              (inst),
        .icache_in         (icache_in),
        .icache_address_in (icache_address_in),
        .icache_received   (icache_received),
        .icache_task_out   (icache_task_out),
        .value_load        (value_load)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    // Model: resident word address per line index, expected outputs.
    logic [31:0] m_res [int];
    logic [31:0] m_inst;
    logic [31:0] exp_q [$];
    bit          exp_idle;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          mon_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] wa);
        if (wa == 32'h0000_1004) return 32'h00A0_0093;
        return wa * 32'h9E37_79B1 + 32'h1357_9BDF;
    endfunction

    function automatic int line_of(input logic [31:0] wa);
        return int'((wa >> 2) % LINES);
    endfunction

    function automatic bit model_hit(input logic [31:0] wa);
        return m_res.exists(line_of(wa)) && (m_res[line_of(wa)] == wa);
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    always @(negedge clk_in) begin
        if (mon_en) begin
            chk("fetch_ready", {31'd0, fetch_ready}, {31'd0, exp_idle && !clear_in});
            chk("icache_in", {31'd0, icache_in}, {31'd0, exp_req});
            if (exp_req) chk("miss_addr", icache_address_in, exp_addr);
            if (inst_valid) begin
                n_pulses++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_inst_valid: got inst_valid=1 inst=0x%08h expected inst_valid=0 at %0t", inst, $time);
                end else begin
                    m_inst = exp_q.pop_front();
                    chk("inst", inst, m_inst);
                end
            end else begin
                chk("inst_hold", inst, m_inst);
            end
        end
    end

    // clr_mode: 0 none, 1 flush while in REQ, 2 flush while in WAIT, 3 flush with the returning data.
    task automatic do_fetch(input logic [31:0] pc, input int clr_mode, input int stall,
                            output bit saw_req, output logic [31:0] saw_addr);
        logic [31:0] wa;
        bit drop;
        int d1;
        int d2;
        wa   = {pc[31:2], 2'b00};
        drop = 0;
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        tick();
        fetch_valid = 1'b0;
        fetch_pc    = $urandom;
        saw_req     = icache_in;
        saw_addr    = icache_address_in;
        if (model_hit(wa)) begin
            exp_q.push_back(mem_data(wa));
            tick();
            chk("hit_pulse_seen", exp_q.size(), 0);
        end else begin
            exp_idle = 0;
            exp_req  = 1;
            exp_addr = wa;
            d1 = $urandom_range(0, 3);
            for (int i = 0; i < d1; i++) begin
                icache_task_out = ($urandom_range(0, 3) == 0);
                value_load      = $urandom;
                if (clr_mode == 1 && i == 0) begin
                    clear_in = 1'b1;
                    drop     = 1;
                end
                tick();
                icache_task_out = 1'b0;
                clear_in        = 1'b0;
            end
            if (stall > 0) begin
                rdy_in = 1'b0;
                repeat (stall) tick();
                rdy_in = 1'b1;
            end
            icache_received = 1'b1;
            if (clr_mode == 1 && d1 == 0) begin
                clear_in = 1'b1;
                drop     = 1;
            end
            tick();
            icache_received = 1'b0;
            clear_in        = 1'b0;
            exp_req         = 0;
            d2 = $urandom_range(0, 3);
            for (int i = 0; i < d2; i++) begin
                icache_received = ($urandom_range(0, 3) == 0);
                if (clr_mode == 2 && i == 0) begin
                    clear_in = 1'b1;
                    drop     = 1;
                end
                tick();
                icache_received = 1'b0;
                clear_in        = 1'b0;
            end
            if (stall > 0) begin
                rdy_in = 1'b0;
                tick();
                rdy_in = 1'b1;
            end
            icache_task_out = 1'b1;
            value_load      = mem_data(wa);
            if (clr_mode == 3 || (clr_mode == 2 && d2 == 0) || (clr_mode == 1 && drop == 0)) begin
                clear_in = 1'b1;
                drop     = 1;
            end
            tick();
            icache_task_out = 1'b0;
            clear_in        = 1'b0;
            value_load      = $urandom;
            m_res[line_of(wa)] = wa;
            exp_idle = 1;
            if (!drop) exp_q.push_back(mem_data(wa));
            tick();
            chk("fill_pulse_seen", exp_q.size(), 0);
        end
    endtask

    task automatic idle_clear(input logic [31:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        clear_in    = 1'b1;
        tick();
        fetch_valid = 1'b0;
        clear_in    = 1'b0;
        tick();
    endtask

    bit          saw;
    logic [31:0] saw_a;
    int          p0;
    logic [31:0] b2b [4];
    logic [31:0] rpc;

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
        icache_received = 1'b0; icache_task_out = 1'b0; value_load = '0;
        m_inst = '0; exp_idle = 1; exp_req = 0; exp_addr = '0; mon_en = 0;
        #2;
        chk("reset_inst_valid", {31'd0, inst_valid}, 0);
        chk("reset_inst", inst, 0);
        chk("reset_icache_in", {31'd0, icache_in}, 0);
        chk("reset_addr", icache_address_in, 0);
        tick();
        rst_in = 1'b1;
        mon_en = 1;
        chk("reset_fetch_ready", {31'd0, fetch_ready}, 1);
        tick();

        // Cold miss then hit
        do_fetch(32'h0000_1004, 0, 0, saw, saw_a);
        chk("cold_miss_req", {31'd0, saw}, 1);
        chk("cold_miss_addr", saw_a, 32'h0000_1004);
        chk("cold_inst", inst, 32'h00A0_0093);
        p0 = n_pulses;
        do_fetch(32'h0000_1004, 0, 0, saw, saw_a);
        chk("refetch_no_req", {31'd0, saw}, 0);
        chk("refetch_pulses", n_pulses - p0, 1);
        chk("refetch_inst", inst, 32'h00A0_0093);

        // Conflict on the same line
        do_fetch(32'h0000_0008, 0, 0, saw, saw_a);
        chk("conflict_first_miss", {31'd0, saw}, 1);
        do_fetch(32'h0000_0048, 0, 0, saw, saw_a);
        chk("conflict_second_miss", {31'd0, saw}, 1);
        do_fetch(32'h0000_0008, 0, 0, saw, saw_a);
        chk("conflict_refetch_miss", {31'd0, saw}, 1);
        do_fetch(32'h0000_0048, 0, 0, saw, saw_a);
        chk("conflict_evicted_miss", {31'd0, saw}, 1);

        // Flush during WAIT, then refetch hits
        p0 = n_pulses;
        do_fetch(32'h0000_0200, 2, 0, saw, saw_a);
        chk("flush_wait_no_pulse", n_pulses - p0, 0);
        do_fetch(32'h0000_0200, 0, 0, saw, saw_a);
        chk("flush_refetch_hit", {31'd0, saw}, 0);
        chk("flush_refetch_pulse", n_pulses - p0, 1);

        // Flush in IDLE: no fetch accepted
        p0 = n_pulses;
        idle_clear(32'h0000_0200);
        chk("idle_clear_no_pulse", n_pulses - p0, 0);

        // Stall during REQ
        do_fetch(32'h0000_030C, 0, 5, saw, saw_a);
        chk("stall_miss_req", {31'd0, saw}, 1);
        chk("stall_inst", inst, mem_data(32'h0000_030C));

        // Back-to-back hits
        b2b[0] = 32'h0000_1004; b2b[1] = 32'h0000_0048;
        b2b[2] = 32'h0000_0200; b2b[3] = 32'h0000_030C;
        p0 = n_pulses;
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 1'b1;
            fetch_pc    = b2b[i];
            tick();
            exp_q.push_back(mem_data(b2b[i]));
        end
        fetch_valid = 1'b0;
        tick();
        chk("b2b_pulses", n_pulses - p0, 4);

        // Async reset with a miss outstanding
        fetch_valid = 1'b1;
        fetch_pc    = 32'h0000_0500;
        tick();
        fetch_valid = 1'b0;
        exp_idle = 0; exp_req = 1; exp_addr = 32'h0000_0500;
        tick();
        icache_received = 1'b1;
        tick();
        icache_received = 1'b0;
        exp_req = 0;
        #3;
        mon_en = 0;
        rst_in = 1'b0;
        #1;
        chk("async_inst_valid", {31'd0, inst_valid}, 0);
        chk("async_inst", inst, 0);
        chk("async_icache_in", {31'd0, icache_in}, 0);
        chk("async_addr", icache_address_in, 0);
        m_res.delete();
        m_inst = '0;
        exp_q.delete();
        exp_idle = 1;
        exp_req  = 0;
        tick();
        tick();
        rst_in          = 1'b1;
        icache_task_out = 1'b1;
        value_load      = 32'hDEAD_BEEF;
        mon_en          = 1;
        tick();
        icache_task_out = 1'b0;
        chk("post_reset_ready", {31'd0, fetch_ready}, 1);
        tick();
        do_fetch(32'h0000_1004, 0, 0, saw, saw_a);
        chk("post_reset_miss", {31'd0, saw}, 1);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            rpc = 32'h0000_4000 | (32'($urandom_range(0, 3)) << (INDEX_BITS + 2))
                  | (32'($urandom_range(0, LINES - 1)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                idle_clear(rpc);
            end else begin
                do_fetch(rpc, ($urandom_range(0, 5) < 4) ? 0 : int'($urandom_range(1, 3)),
                         ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, saw, saw_a);
                chk("rand_req_vs_model", {31'd0, saw}, {31'd0, exp_idle ? saw : 1'b1});
            end
        end

        tick();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
